program_counter: RTL and testbench

- Instruction-fetch program counter for the team's 12-bit-address processor core.
- Holds the current instruction address and drives it to instruction memory.
- Each cycle it either advances sequentially or loads an absolute jump target.
- After reset it waits one start-up cycle at address 0 before it begins advancing.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/program_counter_if.sv | 31 +++
 rtl/pc_next_logic.sv | 33 +++
 rtl/program_counter.sv | 47 ++++
 tb/tb_program_counter.sv | 136 +++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared address-width constants and types for the 12-bit core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 12;

    typedef logic [ADDR_W-1:0] addr_t;

    // Value the program counter takes while reset is asserted.
    localparam addr_t RESET_VECTOR = '0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/program_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_if
// Description : Fetch-side bus between the core control logic and the PC.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_counter_if
    import cpu_pkg::*;
#(
    parameter int D = ADDR_W
);
    logic         absjump_en;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;

    // Control side: requests jumps and observes the fetch address.
    modport master (
        output absjump_en,
        output target,
        input  prog_ctr
    );

    // Program counter side.
    modport slave (
        input  absjump_en,
        input  target,
        output prog_ctr
    );

endinterface : program_counter_if
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_logic
// Description : Next-address selection: hold during start-up, else jump or
//               sequential increment (jump wins).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
    import cpu_pkg::*;
#(
    parameter int D = ADDR_W
) (
    input  wire logic [D-1:0] prog_ctr_i,
    input  wire logic         started_i,
    input  wire logic         absjump_en_i,
    input  wire logic [D-1:0] target_i,
    output logic      [D-1:0] next_addr_o
);

    // Hold / jump / increment mux; increment wraps naturally modulo 2^D.
    always_comb begin
        next_addr_o = prog_ctr_i;
        if (started_i) begin
            if (absjump_en_i) begin
                next_addr_o = target_i;
            end else begin
                next_addr_o = prog_ctr_i + D'(1);
            end
        end
    end

endmodule : pc_next_logic
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Instruction-fetch program counter with a one-cycle start-up
//               hold after reset release and absolute-jump support.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import cpu_pkg::*;
#(
    parameter int D = ADDR_W
) (
    input  wire logic       clk,
    input  wire logic       reset,   // asynchronous, active-low
    program_counter_if.slave bus
);

    logic [D-1:0] prog_ctr_q;
    logic [D-1:0] prog_ctr_d;
    logic         started_q;

    pc_next_logic #(
        .D (D)
    ) u_next (
        .prog_ctr_i   (prog_ctr_q),
        .started_i    (started_q),
        .absjump_en_i (bus.absjump_en),
        .target_i     (bus.target),
        .next_addr_o  (prog_ctr_d)
    );

    // Address and start flag; the first edge after release only sets the flag,
    // which also absorbs any ambiguity around asynchronous reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr_q <= D'(RESET_VECTOR);
            started_q  <= 1'b0;
        end else begin
            prog_ctr_q <= prog_ctr_d;
            started_q  <= 1'b1;
        end
    end

    assign bus.prog_ctr = prog_ctr_q;

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Self-checking bench for program_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;
    import cpu_pkg::*;

    localparam int D = ADDR_W;

    typedef struct {
        logic   en;
        addr_t  tgt;
        addr_t  exp;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    addr_t exp_q[$];

    program_counter_if #(.D(D)) bus ();

    program_counter #(.D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input addr_t act, input addr_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: prog_ctr=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge value, then
    // compare once the edge has passed.
    task automatic step(input logic en, input addr_t tgt, input addr_t exp,
                        input string nm);
        addr_t e;
        bus.absjump_en = en;
        bus.target     = tgt;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, prog_ctr=%h", nm, bus.prog_ctr);
        end else begin
            e = exp_q.pop_front();
            chk(nm, bus.prog_ctr, e);
        end
    endtask

    vec_t vecs[];

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.absjump_en = 1'b0;
        bus.target     = '0;

        // Reset held low for two edges.
        #1;
        chk("reset_async_init", bus.prog_ctr, 12'h000);
        step(1'b0, 12'h000, 12'h000, "reset_hold0");
        step(1'b1, 12'h3C3, 12'h000, "reset_hold_jump_ignored");
        reset = 1'b1;

        vecs = new[17];
        vecs[0]  = '{1'b0, 12'h000, 12'h000};  // start-up hold
        vecs[1]  = '{1'b0, 12'h000, 12'h001};
        vecs[2]  = '{1'b0, 12'h000, 12'h002};
        vecs[3]  = '{1'b0, 12'h000, 12'h003};
        vecs[4]  = '{1'b0, 12'h000, 12'h004};
        vecs[5]  = '{1'b0, 12'h000, 12'h005};
        vecs[6]  = '{1'b1, 12'h123, 12'h123};  // jump
        vecs[7]  = '{1'b0, 12'h777, 12'h124};
        vecs[8]  = '{1'b0, 12'h000, 12'h125};
        vecs[9]  = '{1'b1, 12'hFFE, 12'hFFE};  // wrap-around
        vecs[10] = '{1'b0, 12'h000, 12'hFFF};
        vecs[11] = '{1'b0, 12'h000, 12'h000};
        vecs[12] = '{1'b0, 12'h000, 12'h001};
        vecs[13] = '{1'b1, 12'h040, 12'h040};  // self-loop
        vecs[14] = '{1'b1, 12'h040, 12'h040};
        vecs[15] = '{1'b1, 12'h040, 12'h040};
        vecs[16] = '{1'b0, 12'h040, 12'h041};

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].tgt, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-run at 0x077.
        step(1'b1, 12'h077, 12'h077, "jump_077");
        bus.absjump_en = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_midrun", bus.prog_ctr, 12'h000);
        step(1'b1, 12'h555, 12'h000, "reset_held_jump");
        reset = 1'b1;
        step(1'b0, 12'h000, 12'h000, "restart_hold");
        step(1'b0, 12'h000, 12'h001, "restart_inc");
        step(1'b0, 12'h000, 12'h002, "restart_inc2");

        // Jump requested during the start-up cycle is ignored.
        reset = 1'b0;
        #1;
        chk("async_reset2", bus.prog_ctr, 12'h000);
        step(1'b0, 12'h000, 12'h000, "reset2_hold");
        reset = 1'b1;
        step(1'b1, 12'h2A0, 12'h000, "startup_jump_ignored");
        step(1'b1, 12'h2A0, 12'h2A0, "jump_after_startup");
        step(1'b0, 12'h000, 12'h2A1, "inc_after_jump");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_program_counter
`default_nettype wire
